// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and small op-class helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; serves as abs() on entry and as
// the result sign correction on exit.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle, owning the HI/LO registers.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] oper1,
    input  logic [WIDTH-1:0] oper2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int AW    = 2 * WIDTH + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] mag_q;
    logic             div_q, neg_q, rem_neg_q, div0_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic               sgn;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [AW-1:0]      step_mul, step_div;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic               commit;

    assign sgn = is_signed_op(op);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs1 (
        .value(oper1), .negate(sgn & oper1[WIDTH-1]), .result(abs1));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs2 (
        .value(oper2), .negate(sgn & oper2[WIDTH-1]), .result(abs2));
    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value(acc[2*WIDTH-1:0]), .negate(neg_q), .result(prod_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
        .value(acc[WIDTH-1:0]), .negate(neg_q), .result(quot_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value(acc[2*WIDTH-1:WIDTH]), .negate(rem_neg_q), .result(rem_fix));

    // Multiply: acc = {carry, partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_q : '0)};
    assign step_mul = {1'b0, mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}; trial subtract on the shifted remainder.
    assign div_diff = acc[AW-1:WIDTH-1] - {2'b00, mag_q};
    assign step_div = div_diff[WIDTH+1] ? {acc[2*WIDTH-1:0], 1'b0}
                                        : {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (div0_q) begin
            res_hi = acc[2*WIDTH-1:WIDTH];
            res_lo = acc[WIDTH-1:0];
        end else if (div_q) begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    // A flush arriving in FIX cancels the write, so the visible result and done qualify on it.
    assign commit = (state == ST_FIX) && !flush;
    assign busy   = (state != ST_IDLE);
    assign done   = commit;
    assign div0   = commit & div0_q;
    assign hi     = commit ? res_hi : hi_q;
    assign lo     = commit ? res_lo : lo_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mag_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MDU_MTHI: hi_q <= oper1;
                            MDU_MTLO: lo_q <= oper1;
                            MDU_MULT, MDU_MULTU: begin
                                state     <= ST_RUN;
                                cnt       <= CNT_W'(WIDTH);
                                acc       <= {{(WIDTH+1){1'b0}}, abs2};
                                mag_q     <= abs1;
                                div_q     <= 1'b0;
                                div0_q    <= 1'b0;
                                neg_q     <= sgn & (oper1[WIDTH-1] ^ oper2[WIDTH-1]);
                                rem_neg_q <= 1'b0;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                div_q     <= 1'b1;
                                neg_q     <= sgn & (oper1[WIDTH-1] ^ oper2[WIDTH-1]);
                                rem_neg_q <= sgn & oper1[WIDTH-1];
                                if (oper2 == '0) begin
                                    state  <= ST_FIX;
                                    acc    <= {1'b0, oper1, {WIDTH{1'b1}}};
                                    div0_q <= 1'b1;
                                end else begin
                                    state  <= ST_RUN;
                                    cnt    <= CNT_W'(WIDTH);
                                    acc    <= {{(WIDTH+1){1'b0}}, abs1};
                                    mag_q  <= abs2;
                                    div0_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= div_q ? step_div : step_mul;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
